// File: rtl/display_pkg.sv
// Shared display geometry defaults, widths and the terminal-count compare.
package display_pkg;

  localparam int DEF_PX_W    = 10;
  localparam int DEF_LINE_W  = 10;
  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_FRM_W   = 8;

  localparam int DEF_H_COUNT = 640;
  localparam int DEF_V_COUNT = 480;
  localparam int DEF_STRIDE  = 640;

  // True when a counter value sits on the last position of a span of `count`.
  function automatic logic at_terminal(input logic [31:0] value,
                                       input logic [31:0] count);
    return value == (count - 32'd1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-COUNT counter with increment, soft clear and a last-position flag.
module wrap_counter
  import display_pkg::*;
#(
  parameter int W     = DEF_PX_W,
  parameter int COUNT = DEF_H_COUNT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = at_terminal(32'(cnt_q), 32'(COUNT));
  assign cnt  = cnt_q;

  // Next count: clear beats increment; increment wraps at the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/raster_scan_counter.sv
// Raster position generator: pixel/line counters plus an incrementally built
// frame-buffer address, line/frame boundary flags and a completed-frame count.
module raster_scan_counter
  import display_pkg::*;
#(
  parameter int PX_W    = DEF_PX_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int H_COUNT = DEF_H_COUNT,
  parameter int V_COUNT = DEF_V_COUNT,
  parameter int STRIDE  = DEF_STRIDE,
  parameter int FRM_W   = DEF_FRM_W
) (
  input  logic              clk,
  input  logic              ResetN,
  input  logic              Clear,
  input  logic              IncPx,
  input  logic [ADDR_W-1:0] BaseAddr,
  output logic [PX_W-1:0]   PxOut,
  output logic [LINE_W-1:0] LineOut,
  output logic [ADDR_W-1:0] AddrOut,
  output logic              EndOfLine,
  output logic              EndOfFrame,
  output logic              FrameDone,
  output logic [FRM_W-1:0]  FrameCnt
);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  logic px_last;
  logic line_last;
  logic line_inc;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_start_q, line_start_d;
  logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;

  // The line counter only moves when the pixel counter wraps.
  assign line_inc = IncPx & px_last;

  wrap_counter #(
    .W     (PX_W),
    .COUNT (H_COUNT)
  ) u_px_cnt (
    .clk   (clk),
    .rst_n (ResetN),
    .clr   (Clear),
    .inc   (IncPx),
    .cnt   (PxOut),
    .last  (px_last)
  );

  wrap_counter #(
    .W     (LINE_W),
    .COUNT (V_COUNT)
  ) u_line_cnt (
    .clk   (clk),
    .rst_n (ResetN),
    .clr   (Clear),
    .inc   (line_inc),
    .cnt   (LineOut),
    .last  (line_last)
  );

  assign EndOfLine  = px_last;
  assign EndOfFrame = px_last & line_last;
  assign AddrOut    = addr_q;
  assign FrameDone  = frame_done_q;
  assign FrameCnt   = frame_cnt_q;

  // Address, line-start and frame bookkeeping; Clear outranks IncPx.
  always_comb begin
    addr_d       = addr_q;
    line_start_d = line_start_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (Clear) begin
      addr_d       = BaseAddr;
      line_start_d = BaseAddr;
    end else if (IncPx) begin
      if (EndOfFrame) begin
        addr_d       = BaseAddr;
        line_start_d = BaseAddr;
        frame_cnt_d  = frame_cnt_q + FRM_W'(1);
        frame_done_d = 1'b1;
      end else if (EndOfLine) begin
        addr_d       = line_start_q + STRIDE_A;
        line_start_d = line_start_q + STRIDE_A;
      end else begin
        addr_d       = addr_q + ADDR_W'(1);
      end
    end
  end

  // Address and frame registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!ResetN) begin
      addr_q       <= '0;
      line_start_q <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      line_start_q <= line_start_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
